// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller slice:
//   - access width encodings carried on req_width
//   - controller FSM state encoding
//   - WAIT_CYC ceiling (the wait counter is 4 bits wide)
//   - helpers for lane masks and load extension
// Imported by dmem_ctrl and dmem_bank.
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_RSVD = 2'b10,
        WIDTH_WORD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int WAIT_CYC_MAX = 15;
    localparam int LANES        = 4;

    // Which of the four byte lanes an access of the given width touches.
    // The reserved encoding touches nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 4'b0001;
            WIDTH_HALF: return 4'b0011;
            WIDTH_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Narrow loads are sign- or zero-extended from the low lanes of the raw
    // little-endian word; word loads pass through unchanged.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  width,
                                                input logic        sign);
        case (width)
            WIDTH_BYTE: return {{24{sign & raw[7]}}, raw[7:0]};
            WIDTH_HALF: return {{16{sign & raw[15]}}, raw[15:0]};
            WIDTH_WORD: return raw;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response bus between a requester (master) and dmem_ctrl (slave).
//   req_valid  : request present
//   req_ready  : controller can accept a request
//   req_we     : 1 = store, 0 = load
//   req_width  : 00 byte, 01 half, 11 word, 10 reserved
//   req_sign   : load extension, 1 signed / 0 zero
//   req_addr   : byte address
//   req_wdata  : store data (low bytes for narrow widths)
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : extended load data, 0 for stores and errors
//   rsp_err    : access rejected, valid with rsp_valid
// -----------------------------------------------------------------------------
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_width;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// Byte-organised storage with four write-enabled byte lanes. Lane k maps to
// byte index (addr + k) mod DEPTH_BYTES, so multi-byte accesses wrap from the
// top of the array back to byte 0 and upper address bits are ignored.
// Reads are combinational over the same four wrapped indices.
// Contents are never reset.
// Ports:
//   clk    : clock, rising edge
//   we     : write strobe for this cycle
//   lanes  : per-lane write enable (lane 0 = lowest address)
//   addr   : byte address of lane 0
//   wdata  : lane k data in wdata[8k +: 8]
//   rdata  : lane k data in rdata[8k +: 8]
// -----------------------------------------------------------------------------
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  lanes,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int ADDR_W = $clog2(DEPTH_BYTES);

    logic [7:0]        mem [DEPTH_BYTES];
    logic [ADDR_W-1:0] idx [LANES];

    // Truncating the 32-bit sum to ADDR_W bits is the modulo that gives the
    // wrap-around for a power-of-two depth.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            idx[k] = ADDR_W'(addr + 32'(k));
        end
    end

    // Byte-lane writes; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (lanes[k]) begin
                    mem[idx[k]] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Single-outstanding data-memory controller. A request is accepted in IDLE,
// the controller spends WAIT_CYC cycles in WAIT, then commits the store /
// samples the load on the edge entering RESP and pulses rsp_valid for that
// one RESP cycle. Latency from handshake edge to rsp_valid is WAIT_CYC+1.
// Parameters:
//   DEPTH_BYTES : byte capacity, power of two, 4..65536
//   WAIT_CYC    : wait cycles per access, 0..15
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : dmem_if slave modport (request/response handshake)
// Build option:
//   DMEM_MISALIGN_TRAP_EN : when defined, half accesses with addr[0]=1 and
//   word accesses with addr[1:0]!=0 are rejected with rsp_err; otherwise they
//   proceed byte-wise with wrap-around.
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYC    = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);

    localparam int         WAIT_EFF  = (WAIT_CYC > WAIT_CYC_MAX) ? WAIT_CYC_MAX : WAIT_CYC;
    localparam logic [3:0] WAIT_INIT = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;
    localparam bit         SKIP_WAIT = (WAIT_EFF == 0);

    state_e      state;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [1:0]  lat_width;
    logic        lat_sign;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        idle;
    logic        handshake;
    logic        enter_resp;

    logic        acc_we;
    logic [1:0]  acc_width;
    logic        acc_sign;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        misaligned;
    logic        acc_err;
    logic [3:0]  acc_lanes;
    logic        bank_we;
    logic [31:0] bank_rdata;
    logic [31:0] resp_rdata;

    assign idle       = (state == ST_IDLE);
    assign handshake  = idle & bus.req_valid;
    assign enter_resp = (handshake & SKIP_WAIT) |
                        ((state == ST_WAIT) & (wait_cnt == 4'd0));

    // The access being worked on: live bus fields while in IDLE (needed when
    // WAIT_CYC is 0 and the handshake edge is also the commit edge), the
    // latched copy otherwise.
    always_comb begin
        if (idle) begin
            acc_we    = bus.req_we;
            acc_width = bus.req_width;
            acc_sign  = bus.req_sign;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = lat_we;
            acc_width = lat_width;
            acc_sign  = lat_sign;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((acc_width == WIDTH_HALF) && acc_addr[0]) ||
                        ((acc_width == WIDTH_WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign acc_err    = (acc_width == WIDTH_RSVD) | misaligned;
    assign acc_lanes  = lane_mask(acc_width);

    // rst_n gates the write so a clock edge during reset can never commit.
    assign bank_we    = enter_resp & acc_we & ~acc_err & rst_n;
    assign resp_rdata = (acc_we | acc_err) ? 32'd0
                                           : extend_load(bank_rdata, acc_width, acc_sign);

    dmem_bank #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .lanes (acc_lanes),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (bank_rdata)
    );

    // Controller FSM with registered response outputs. A reset mid-access
    // returns straight to IDLE, so an uncommitted store is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            lat_we      <= 1'b0;
            lat_width   <= 2'b00;
            lat_sign    <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        lat_we    <= bus.req_we;
                        lat_width <= bus.req_width;
                        lat_sign  <= bus.req_sign;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        if (SKIP_WAIT) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                            rsp_rdata_q <= resp_rdata;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rsp_rdata_q <= resp_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Randomised bench for dmem_ctrl against a byte-array reference model.
// Main instance: DEPTH_BYTES=1024, WAIT_CYC=1. A second instance with
// WAIT_CYC=3 covers latency and reset in the middle of a store.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int DEPTH  = 1024;
    localparam int WAIT_M = 1;
    localparam int DEPTH3 = 64;
    localparam int WAIT3  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;

    always #5 clk = ~clk;

    dmem_if bus ();
    dmem_if bus3 ();

    dmem_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYC    (WAIT_M)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmem_ctrl #(
        .DEPTH_BYTES (DEPTH3),
        .WAIT_CYC    (WAIT3)
    ) u_dut_w3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (bus3)
    );

    int          check_count = 0;
    int          error_count = 0;
    logic [7:0]  model_mem [DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour: bytes at (addr+k) mod DEPTH, little-endian,
    // narrow loads extended arithmetically.
    task automatic modelAccess(input logic we, input logic [1:0] width, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp_rdata, output logic exp_err);
        int          nbytes;
        int unsigned idx;
        longint      value;
        longint      half_range;
        exp_err   = (width == 2'b10);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (width == 2'b01 && (addr % 2) != 0) exp_err = 1'b1;
        if (width == 2'b11 && (addr % 4) != 0) exp_err = 1'b1;
`endif
        exp_rdata = 32'd0;
        if (!exp_err) begin
            nbytes = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
            if (we) begin
                for (int k = 0; k < nbytes; k++) begin
                    idx = (addr + 32'(k)) % DEPTH;
                    model_mem[idx] = 8'((wdata >> (8 * k)) & 32'hFF);
                end
            end else begin
                value = 0;
                for (int k = 0; k < nbytes; k++) begin
                    idx   = (addr + 32'(k)) % DEPTH;
                    value = value + (longint'(model_mem[idx]) << (8 * k));
                end
                half_range = longint'(1) << (8 * nbytes - 1);
                if (sign && nbytes < 4 && value >= half_range) begin
                    value = value - 2 * half_range;
                end
                exp_rdata = value[31:0];
            end
        end
    endtask

    // One access on the main instance. Called and returns at a falling edge.
    // With hold set, req_valid stays high through the WAIT cycle.
    task automatic applyStimulus(input logic we, input logic [1:0] width, input logic sign,
                                 input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        bit          seen;
        modelAccess(we, width, sign, addr, wdata, exp_rdata, exp_err);
        checkOutput("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_we    = we;
        bus.req_width = width;
        bus.req_sign  = sign;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        lat  = 0;
        seen = 1'b0;
        if (hold) begin
            @(negedge clk);
            lat = 1;
            checkOutput("ready_busy", 32'(bus.req_ready), 32'd0);
            if (bus.rsp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end else begin
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
            checkOutput("latency", 32'(lat), 32'(WAIT_M + 1));
            checkOutput("rdata", bus.rsp_rdata, exp_rdata);
            checkOutput("err", 32'(bus.rsp_err), 32'(exp_err));
            @(negedge clk);
            checkOutput("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // Word access on the WAIT_CYC=3 instance. Called and returns at a falling edge.
    task automatic access3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        bit seen;
        seen           = 1'b0;
        rdata          = 32'd0;
        err            = 1'b0;
        bus3.req_we    = we;
        bus3.req_width = 2'b11;
        bus3.req_sign  = 1'b0;
        bus3.req_addr  = addr;
        bus3.req_wdata = wdata;
        bus3.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus3.req_valid = 1'b0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus3.rsp_valid) begin
                seen  = 1'b1;
                rdata = bus3.rsp_rdata;
                err   = bus3.rsp_err;
            end
        end
        if (!seen) lat = -1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r3;
        logic        e3;
        int          lat3;
        bit          seen3;
        logic [31:0] prior;
        logic [31:0] raddr;
        logic [1:0]  rwidth;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_width  = 2'b00;
        bus.req_sign   = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus3.req_valid = 1'b0;
        bus3.req_we    = 1'b0;
        bus3.req_width = 2'b00;
        bus3.req_sign  = 1'b0;
        bus3.req_addr  = 32'd0;
        bus3.req_wdata = 32'd0;
        rst_n  = 1'b0;
        rst3_n = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst3_ready", 32'(bus3.req_ready), 32'd1);

        // Known contents everywhere; upper address bits are noise.
        for (int i = 0; i < DEPTH / 4; i++) begin
            applyStimulus(1'b1, 2'b11, 1'b0, (($urandom % 16) << 16) | 32'(i * 4), $urandom, 1'b0);
        end

        applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        checkOutput("signed_byte_13", last_rdata, 32'hFFFFFFDE);
        checkOutput("signed_byte_13_err", 32'(last_err), 32'd0);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h20, 32'hAAAA8001, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
        checkOutput("half_signed", last_rdata, 32'hFFFF8001);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
        checkOutput("half_unsigned", last_rdata, 32'h00008001);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1);

`ifndef DMEM_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h3FE, 32'h11223344, 1'b0);
        checkOutput("wrap_store_err", 32'(last_err), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h3FE, 32'h0, 1'b0);
        checkOutput("wrap_3fe", last_rdata, 32'h44);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 1'b0);
        checkOutput("wrap_3ff", last_rdata, 32'h33);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h000, 32'h0, 1'b0);
        checkOutput("wrap_000", last_rdata, 32'h22);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 1'b0);
        checkOutput("wrap_001", last_rdata, 32'h11);
`else
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
        prior = last_rdata;
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h21, 32'h55667788, 1'b0);
        checkOutput("trap_err", 32'(last_err), 32'd1);
        checkOutput("trap_rdata", last_rdata, 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
        checkOutput("trap_unchanged", last_rdata, prior);
`endif

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("rsvd_err", 32'(last_err), 32'd1);
        checkOutput("rsvd_rdata", last_rdata, 32'd0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFFFFFF, 1'b0);

        for (int n = 0; n < 400; n++) begin
            raddr  = $urandom;
            if (($urandom % 3) == 0) begin
                raddr = (raddr & ~32'(DEPTH - 1)) | 32'(DEPTH - 1 - int'($urandom % 3));
            end
            rwidth = 2'($urandom % 4);
            applyStimulus(1'($urandom % 2), rwidth, 1'($urandom % 2), raddr, $urandom,
                          (($urandom % 4) == 0));
        end

        // WAIT_CYC=3 instance: latency, then reset one cycle after a store handshake.
        access3(1'b1, 32'h8, 32'hCAFEF00D, r3, e3, lat3);
        checkOutput("w3_latency", 32'(lat3), 32'(WAIT3 + 1));
        checkOutput("w3_store_err", 32'(e3), 32'd0);
        bus3.req_we    = 1'b1;
        bus3.req_width = 2'b11;
        bus3.req_addr  = 32'h8;
        bus3.req_wdata = 32'h12345678;
        bus3.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus3.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst3_n = 1'b0;
        seen3  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus3.rsp_valid) seen3 = 1'b1;
        end
        rst3_n = 1'b1;
        @(negedge clk);
        checkOutput("w3_ready_after_rst", 32'(bus3.req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (bus3.rsp_valid) seen3 = 1'b1;
        end
        checkOutput("w3_no_rsp", 32'(seen3), 32'd0);
        access3(1'b0, 32'h8, 32'h0, r3, e3, lat3);
        checkOutput("w3_unchanged", r3, 32'hCAFEF00D);
        checkOutput("w3_load_err", 32'(e3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024: byte capacity; power of two, 4..65536.
REQ-002 SHALL have parameter WAIT_CYC, default 1: extra wait cycles per access, 0..15.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  controller can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_width  in  2  access width: 00 byte, 01 half, 11 word, 10 reserved.
REQ-009 SHALL have port req_sign  in  1  load extension: 1 signed, 0 zero.
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, low bytes used for narrow widths.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  out  1  access rejected; valid with rsp_valid.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, skipping WAIT when WAIT_CYC = 0.
REQ-016 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready on a rising edge; all req_* fields latched at that edge.
REQ-017 SHALL hold one outstanding request; req_valid outside IDLE ignored.
REQ-018 SHALL stay in WAIT exactly WAIT_CYC cycles via a 4-bit down-counter.
REQ-019 SHALL commit stores and sample load data on the edge entering RESP; rsp_valid high for exactly that one cycle, no backpressure.
REQ-020 SHALL give latency WAIT_CYC+1 cycles from handshake edge to rsp_valid.
REQ-021 SHALL return to IDLE after RESP; next handshake earliest in cycle after rsp_valid.
REQ-022 SHALL store little-endian: byte k of a word at index+k.
REQ-023 SHALL index bytes as (addr + k) mod DEPTH_BYTES; upper address bits ignored; multi-byte accesses wrap past top to byte 0.
REQ-024 SHALL extend loads: byte/half sign-extended when req_sign=1 else zero-extended; word unchanged.
REQ-025 SHALL treat width 10 as error: rsp_err=1, no write, rsp_rdata=0.
REQ-026 SHALL leave memory unchanged by loads and by rejected stores.

Reset
REQ-027 SHALL on rst_n low force state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 1 once rst_n high.
REQ-028 SHALL drop an in-flight request on reset mid-access; a store not yet committed SHALL NOT be written.
REQ-029 SHALL NOT reset memory contents.

Configuration
REQ-030 SHALL honour macro DMEM_MISALIGN_TRAP_EN.
REQ-031 With macro: half with addr[0]=1 or word with addr[1:0]!=0 SHALL respond rsp_err=1, rsp_rdata=0, no write, same latency.
REQ-032 Without macro: misaligned accesses SHALL proceed byte-wise per REQ-023 with rsp_err=0.

Structure
REQ-033 SHALL place width encodings, FSM state enum and WAIT_CYC max in shared package dmem_pkg.
REQ-034 SHALL use one sub-module dmem_bank: byte array, 4 write-enabled byte lanes, combinational 4-byte read with wrapped indices.

Verification
REQ-035 WAIT_CYC=1: word store 0xDEADBEEF @0x10, then signed-byte load @0x13 -> rsp_valid 2 cycles after each handshake, rdata 0xFFFFFFDE, err 0.
REQ-036 Half store 0x8001 @0x20, loads @0x20 signed/unsigned -> 0xFFFF8001 / 0x00008001; word @0x20 upper bytes unchanged.
REQ-037 DEPTH_BYTES=1024, word store 0x11223344 @0x3FE (macro off) -> bytes 0x3FE=0x44, 0x3FF=0x33, 0x000=0x22, 0x001=0x11; err 0.
REQ-038 Macro on: word store @0x21 -> err 1, rdata 0; word load @0x20 returns prior contents.
REQ-039 rst_n low one cycle after store handshake (WAIT_CYC=3) -> no rsp_valid, target bytes unchanged, req_ready 1 after release.
REQ-040 Width 10 load @0x0 -> err 1, rdata 0; req_valid held high during WAIT ignored, req_ready 0 until IDLE.
